// File: rtl/sti_rx_deser.sv
// Serial-to-parallel receiver: collects 8/16/24/32-bit frames from a qualified
// bit stream and hands them to a single-entry output register with valid/ready.
module sti_rx_deser (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_load,
   input  logic [1:0]  cfg_length,
   input  logic        cfg_msb,
   input  logic        cfg_fill,
   input  logic        si_valid,
   input  logic        si_data,
   input  logic        po_ready,
   output logic        po_valid,
   output logic [31:0] po_word,
   output logic [15:0] po_payload,
   output logic        po_abort,
   output logic        po_ovf,
   output logic        busy,
   output logic [7:0]  frame_cnt
);

   // state | meaning
   // IDLE  | waiting for the first bit of a frame; cfg_load honoured here
   // RECV  | collecting bits; a gap in si_valid truncates the frame
   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [1:0]  len_q;
   logic        msb_q, fill_q;
   logic [5:0]  bit_cnt, bit_cnt_nxt, cnt_inc, n_bits;
   logic [31:0] shreg, shreg_nxt;
   logic        done, abort_nxt, cfg_take;
   logic        load_out, drop_out;
   logic [15:0] payload_nxt;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The first bit always lands in word[0] whatever the order, so a config
   // loaded in the same cycle only needs to be in the latched regs by RECV.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      done        = 1'b0;
      abort_nxt   = 1'b0;
      cfg_take    = 1'b0;
      n_bits      = {1'b0, len_q, 3'b000} + 6'd8;
      cnt_inc     = bit_cnt + 6'd1;
      case (state)
         IDLE: begin
            cfg_take = cfg_load;
            if (si_valid) begin
               shreg_nxt   = {31'd0, si_data};
               bit_cnt_nxt = 6'd1;
               state_nxt   = RECV;
            end
         end
         RECV: begin
            if (si_valid) begin
               if (msb_q) shreg_nxt = {shreg[30:0], si_data};
               else       shreg_nxt[bit_cnt[4:0]] = si_data;
               bit_cnt_nxt = cnt_inc;
               if (cnt_inc == n_bits) begin
                  done        = 1'b1;
                  bit_cnt_nxt = 6'd0;
                  state_nxt   = IDLE;
               end
            end else begin
               abort_nxt   = 1'b1;
               bit_cnt_nxt = 6'd0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      payload_nxt = shreg_nxt[15:0];
      case (len_q)
         2'b00:   payload_nxt = {8'h00, shreg_nxt[7:0]};
         2'b01:   payload_nxt = shreg_nxt[15:0];
         2'b10:   payload_nxt = fill_q ? shreg_nxt[23:8]  : shreg_nxt[15:0];
         default: payload_nxt = fill_q ? shreg_nxt[31:16] : shreg_nxt[15:0];
      endcase
   end

   assign load_out = done && (!po_valid || po_ready);
   assign drop_out = done && po_valid && !po_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q      <= 2'b00;
         msb_q      <= 1'b1;
         fill_q     <= 1'b0;
         bit_cnt    <= 6'd0;
         shreg      <= 32'd0;
         po_valid   <= 1'b0;
         po_word    <= 32'd0;
         po_payload <= 16'd0;
         po_abort   <= 1'b0;
         po_ovf     <= 1'b0;
         frame_cnt  <= 8'd0;
      end else begin
         if (cfg_take) begin
            len_q  <= cfg_length;
            msb_q  <= cfg_msb;
            fill_q <= cfg_fill;
         end
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         po_abort <= abort_nxt;
         if (load_out) begin
            po_word    <= shreg_nxt;
            po_payload <= payload_nxt;
            po_valid   <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
         end else if (po_ready) begin
            po_valid <= 1'b0;
         end
         if (drop_out) po_ovf <= 1'b1;
      end
   end

   assign busy = (state == RECV);

endmodule

// File: tb/tb_sti_rx_deser.sv
// Directed bench for sti_rx_deser: stimulus pushes expected words to a queue,
// a negedge monitor pops and compares at every accepted output word.
module tb_sti_rx_deser;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_load;
   logic [1:0]  cfg_length;
   logic        cfg_msb, cfg_fill;
   logic        si_valid, si_data;
   logic        po_ready;
   logic        po_valid;
   logic [31:0] po_word;
   logic [15:0] po_payload;
   logic        po_abort, po_ovf, busy;
   logic [7:0]  frame_cnt;

   int checks = 0;
   int errors = 0;
   logic [47:0] exp_q[$];

   sti_rx_deser dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
      .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .si_valid(si_valid), .si_data(si_data),
      .po_ready(po_ready), .po_valid(po_valid), .po_word(po_word),
      .po_payload(po_payload), .po_abort(po_abort), .po_ovf(po_ovf),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // cfg_load, if set by the caller, applies to the first bit only
   task automatic send_frame(input logic [31:0] val, input int n, input bit msb);
      for (int i = 0; i < n; i++) begin
         si_valid = 1'b1;
         si_data  = msb ? val[n-1-i] : val[i];
         tick();
         cfg_load = 1'b0;
      end
   endtask

   task automatic load_cfg(input logic [1:0] len, input logic msb, input logic fill);
      cfg_load = 1'b1; cfg_length = len; cfg_msb = msb; cfg_fill = fill;
      si_valid = 1'b0;
      tick();
      cfg_load = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && po_valid && po_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got 0x%0h/0x%0h with no word expected", po_word, po_payload);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            if ({po_word, po_payload} !== e) begin
               errors++;
               $display("FAIL out_word: got 0x%0h/0x%0h expected 0x%0h/0x%0h",
                        po_word, po_payload, e[47:16], e[15:0]);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; cfg_load = 1'b0; cfg_length = 2'b00; cfg_msb = 1'b1; cfg_fill = 1'b0;
      si_valid = 1'b0; si_data = 1'b0; po_ready = 1'b0;
      repeat (3) tick();
      check("rst_po_valid", 32'(po_valid), 32'd0);
      check("rst_po_word", po_word, 32'd0);
      check("rst_po_payload", 32'(po_payload), 32'd0);
      check("rst_po_abort", 32'(po_abort), 32'd0);
      check("rst_po_ovf", 32'(po_ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      reset = 1'b0;

      // 8-bit MSB-first 0xA5, latency check around the last bit
      load_cfg(2'b00, 1'b1, 1'b0);
      send_frame(32'h52, 7, 1'b1);
      check("a5_busy", 32'(busy), 32'd1);
      check("a5_valid_early", 32'(po_valid), 32'd0);
      exp_q.push_back({32'h000000A5, 16'h00A5});
      send_frame(32'h1, 1, 1'b1);
      si_valid = 1'b0;
      check("a5_valid", 32'(po_valid), 32'd1);
      check("a5_word", po_word, 32'h000000A5);
      check("a5_cnt", 32'(frame_cnt), 32'd1);
      check("a5_busy_done", 32'(busy), 32'd0);
      po_ready = 1'b1;
      tick();
      check("a5_valid_fall", 32'(po_valid), 32'd0);

      // 32-bit LSB-first, cfg loaded together with the first bit
      cfg_load = 1'b1; cfg_length = 2'b11; cfg_msb = 1'b0; cfg_fill = 1'b1;
      exp_q.push_back({32'h12340000, 16'h1234});
      send_frame(32'h12340000, 32, 1'b0);
      load_cfg(2'b11, 1'b0, 1'b0);
      exp_q.push_back({32'h00001234, 16'h1234});
      send_frame(32'h00001234, 32, 1'b0);
      si_valid = 1'b0;
      tick();
      check("l32_cnt", 32'(frame_cnt), 32'd3);

      // 16-bit frame truncated after 5 bits, then a good one
      load_cfg(2'b01, 1'b1, 1'b0);
      send_frame(32'h1B, 5, 1'b1);
      si_valid = 1'b0;
      tick();
      check("abort_pulse", 32'(po_abort), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      tick();
      check("abort_one_cycle", 32'(po_abort), 32'd0);
      check("abort_no_valid", 32'(po_valid), 32'd0);
      check("abort_cnt", 32'(frame_cnt), 32'd3);
      exp_q.push_back({32'h0000BEAD, 16'hBEAD});
      send_frame(32'hBEAD, 16, 1'b1);
      si_valid = 1'b0;
      tick();
      check("after_abort_cnt", 32'(frame_cnt), 32'd4);

      // back-to-back with output stalled: second frame dropped
      load_cfg(2'b00, 1'b1, 1'b0);
      po_ready = 1'b0;
      exp_q.push_back({32'h0000003C, 16'h003C});
      send_frame(32'h3C, 8, 1'b1);
      send_frame(32'hC3, 8, 1'b1);
      si_valid = 1'b0;
      tick();
      check("ovf_word_held", po_word, 32'h3C);
      check("ovf_sticky", 32'(po_ovf), 32'd1);
      check("ovf_cnt", 32'(frame_cnt), 32'd5);
      check("ovf_valid", 32'(po_valid), 32'd1);
      po_ready = 1'b1;
      tick();
      check("ovf_valid_fall", 32'(po_valid), 32'd0);
      po_ready = 1'b0;

      // accept and load at the same edge keeps po_valid high
      exp_q.push_back({32'h0000005A, 16'h005A});
      send_frame(32'h5A, 8, 1'b1);
      exp_q.push_back({32'h00000081, 16'h0081});
      send_frame(32'h40, 7, 1'b1);
      po_ready = 1'b1;
      send_frame(32'h1, 1, 1'b1);
      si_valid = 1'b0;
      check("same_edge_valid", 32'(po_valid), 32'd1);
      check("same_edge_word", po_word, 32'h81);
      check("same_edge_cnt", 32'(frame_cnt), 32'd7);
      tick();
      check("ovf_still_set", 32'(po_ovf), 32'd1);

      // reset in the middle of a 24-bit frame, then a fresh frame
      load_cfg(2'b10, 1'b1, 1'b1);
      send_frame(32'h5F7, 11, 1'b1);
      reset = 1'b1; si_valid = 1'b1; si_data = 1'b1;
      tick();
      check("mid_rst_abort", 32'(po_abort), 32'd0);
      check("mid_rst_valid", 32'(po_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ovf", 32'(po_ovf), 32'd0);
      check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
      reset = 1'b0; si_valid = 1'b0;
      tick();
      check("post_rst_abort", 32'(po_abort), 32'd0);
      cfg_load = 1'b1; cfg_length = 2'b10; cfg_msb = 1'b1; cfg_fill = 1'b1;
      exp_q.push_back({32'h00BEEF00, 16'hBEEF});
      send_frame(32'hBEEF00, 24, 1'b1);
      si_valid = 1'b0;
      check("fresh_cnt", 32'(frame_cnt), 32'd1);

      // 255 more frames wrap the counter to zero
      load_cfg(2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 255; i++) begin
         exp_q.push_back({24'd0, 8'(i), 8'h00, 8'(i)});
         send_frame(32'(i), 8, 1'b1);
      end
      si_valid = 1'b0;
      tick();
      check("cnt_wrap", 32'(frame_cnt), 32'd0);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sti_rx_deser.md
STI_RX_DESER -- requirements
Module: sti_rx_deser

Interface
REQ-001 The module SHALL have clock clk and reset reset (synchronous, active-high).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- cfg_load  in  1  latch cfg_* fields; honoured only in IDLE
- cfg_length  in  2  frame length: 00=8, 01=16, 10=24, 11=32 bits
- cfg_msb  in  1  1=MSB-first stream, 0=LSB-first stream
- cfg_fill  in  1  24/32-bit only: 1=payload in upper 16 bits, 0=payload in lower 16 bits
- si_valid  in  1  serial bit qualifier
- si_data  in  1  serial bit
- po_ready  in  1  consumer accepts the output word
- po_valid  out  1  output word valid (held until accepted)
- po_word  out  32  received frame, right-aligned, upper unused bits zero
- po_payload  out  16  recovered 16-bit payload
- po_abort  out  1  one-cycle pulse: frame truncated
- po_ovf  out  1  sticky: completed frame dropped, output still occupied
- busy  out  1  high in RECV
- frame_cnt  out  8  count of frames delivered to the output register

Function
REQ-003 FSM states SHALL be IDLE and RECV only.
REQ-004 In IDLE, cfg_load=1 SHALL latch cfg_length, cfg_msb and cfg_fill; in RECV, cfg_load SHALL be ignored.
REQ-005 If cfg_load and si_valid are both high in IDLE, the new cfg SHALL apply to the frame starting that cycle.
REQ-006 In IDLE, si_valid=1 SHALL capture si_data as bit 0 of the frame, set the bit counter to 1, and go to RECV.
REQ-007 N SHALL be 8/16/24/32 per the latched length; the bit counter SHALL be 6 bits wide.
REQ-008 MSB-first capture SHALL shift left with the new bit at LSB: word <= {word[30:0], si_data}.
REQ-009 LSB-first capture SHALL place bit k at word[k].
REQ-010 The shift register SHALL be cleared at frame start, so bits [31:N] are zero on completion.
REQ-011 In RECV with si_valid=1, each cycle SHALL capture one bit; on the N-th bit the FSM SHALL return to IDLE.
REQ-012 Back-to-back frames SHALL be accepted: si_valid high in the cycle after the last bit starts a new frame with no gap.
REQ-013 In RECV with si_valid=0, the frame SHALL be discarded, po_abort SHALL pulse for exactly one cycle, and the FSM SHALL go to IDLE.
REQ-014 On completion, if po_valid=0 or po_ready=1 in that cycle, po_word/po_payload SHALL load at that edge, po_valid SHALL be 1 from the next cycle, and frame_cnt SHALL increment.
- Latency: 1 cycle after the edge sampling the last bit.
REQ-015 On completion with po_valid=1 and po_ready=0, the frame SHALL be dropped, po_ovf SHALL set, and frame_cnt SHALL be unchanged.
REQ-016 po_valid SHALL fall after an edge with po_ready=1, unless a new word loads at that same edge.
REQ-017 po_word/po_payload SHALL remain stable while po_valid=1 and po_ready=0.
REQ-018 po_payload mapping SHALL be:
- 8-bit: {8'h00, word[7:0]}
- 16-bit: word[15:0]
- 24-bit: word[23:8] when fill=1, word[15:0] when fill=0
- 32-bit: word[31:16] when fill=1, word[15:0] when fill=0
REQ-019 frame_cnt SHALL wrap 255 -> 0.
REQ-020 busy SHALL equal (state == RECV).

Reset
REQ-021 Reset SHALL set:
- state IDLE, bit counter 0, shift register 0
- po_valid, po_word, po_payload, po_abort, po_ovf, busy, frame_cnt all 0
- latched cfg: length 00, msb 1, fill 0
REQ-022 Reset SHALL take priority over all inputs, including mid-frame: a partial frame is discarded with no po_abort pulse.
REQ-023 po_ovf SHALL clear only on reset.

Verification
REQ-024 8-bit MSB-first, bits 1,0,1,0,0,1,0,1 -> po_word=0x000000A5, po_payload=0x00A5, po_valid one cycle after bit 8, frame_cnt=1.
REQ-025 32-bit LSB-first fill=1, stream is 0x12340000 LSB-first -> po_word=0x12340000, po_payload=0x1234; with fill=0 and stream 0x00001234 -> po_payload=0x1234.
REQ-026 16-bit, si_valid drops after 5 bits -> po_abort one-cycle pulse, po_valid stays 0, frame_cnt unchanged, next frame received correctly.
REQ-027 Two back-to-back 8-bit frames 0x3C and 0xC3 with po_ready=0 -> po_word holds 0x3C, po_ovf=1, frame_cnt=1; po_ready=1 -> po_valid falls.
REQ-028 24-bit fill=1 MSB-first payload 0xBEEF, reset asserted at bit 12 then a fresh frame -> no abort, po_valid stays 0 through reset, fresh frame gives po_word=0x00BEEF00, po_payload=0xBEEF.
